fb_write_port: RTL

//  Receiving end of the drawer pixel interface: accepts (x, y, colour, write) pixels from the
//  map/HUD/sprite drawers and commits them to the VGA frame-buffer write port.

---
 rtl/fb_write_port_if.sv | 26 ++
 rtl/fb_write_port.sv | 103 ++++++++++
 2 files changed

// File: rtl/fb_write_port_if.sv
// Drawer pixel handshake and frame-buffer write bus for fb_write_port.
// Master is the drawer/frame-buffer side. Slave is the write port itself.
interface fb_write_port_if;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_x;
    logic [7:0]  in_y;
    logic [5:0]  in_colour;
    logic        fb_stall;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [5:0]  fb_data;
    logic        clipped;
    logic [16:0] pix_count;
    logic        idle;

    modport master (
        output in_valid, in_x, in_y, in_colour, fb_stall,
        input  in_ready, fb_we, fb_addr, fb_data, clipped, pix_count, idle
    );

    modport slave (
        input  in_valid, in_x, in_y, in_colour, fb_stall,
        output in_ready, fb_we, fb_addr, fb_data, clipped, pix_count, idle
    );
endinterface

// File: rtl/fb_write_port.sv
// Frame-buffer write port: FIFO-buffers drawer pixels, clips off-screen ones and emits linear writes.
// Optional macro FB_TRANSPARENT_EN: colour 6'h3F on-screen is silently skipped (sprite key).
module fb_write_port #(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 240,
    parameter int unsigned DEPTH  = 4
) (
    input  logic             clock,
    input  logic             reset,
    fb_write_port_if.slave   bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned ADDR_W = 17;
    localparam int unsigned COL_W  = 6;
    localparam logic [COL_W-1:0] KEY_COLOUR = COL_W'(6'h3F);

    typedef struct packed {
        logic [8:0]       x;
        logic [7:0]       y;
        logic [COL_W-1:0] colour;
    } pixel_t;

    pixel_t            mem [DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              full_c;
    logic              empty_c;
    logic              push_c;
    logic              pop_c;
    logic              on_screen_c;
    logic              skip_c;
    pixel_t            head_c;

    logic              fb_we_q;
    logic [ADDR_W-1:0] fb_addr_q;
    logic [COL_W-1:0]  fb_data_q;
    logic              clipped_q;
    logic [ADDR_W-1:0] pix_count_q;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        full_c      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
        empty_c     = (wr_ptr == rd_ptr);
        push_c      = bus.in_valid && !full_c;
        pop_c       = !bus.fb_stall && !empty_c;
        head_c      = mem[rd_ptr[PTR_W-1:0]];
        on_screen_c = (10'(head_c.x) < 10'(WIDTH)) && (9'(head_c.y) < 9'(HEIGHT));
`ifdef FB_TRANSPARENT_EN
        skip_c      = (head_c.colour == KEY_COLOUR);
`else
        skip_c      = 1'b0;
`endif
    end

    always_ff @(posedge clock) begin
        if (push_c) begin
            mem[wr_ptr[PTR_W-1:0]] <= '{x: bus.in_x, y: bus.in_y, colour: bus.in_colour};
        end
    end

    // Output stage: while stalled everything holds except the clipped pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
            clipped_q   <= 1'b0;
            pix_count_q <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
            clipped_q <= 1'b0;
            if (!bus.fb_stall) begin
                fb_we_q <= 1'b0;
                if (!empty_c) begin
                    if (!on_screen_c) begin
                        clipped_q <= 1'b1;
                    end else if (!skip_c) begin
                        fb_we_q     <= 1'b1;
                        fb_addr_q   <= ADDR_W'(head_c.y) * ADDR_W'(WIDTH) + ADDR_W'(head_c.x);
                        fb_data_q   <= head_c.colour;
                        pix_count_q <= pix_count_q + ADDR_W'(1);
                    end
                end
            end
        end
    end

    assign bus.in_ready  = !full_c;
    assign bus.idle      = empty_c && !fb_we_q;
    assign bus.fb_we     = fb_we_q;
    assign bus.fb_addr   = fb_addr_q;
    assign bus.fb_data   = fb_data_q;
    assign bus.clipped   = clipped_q;
    assign bus.pix_count = pix_count_q;
endmodule
